mem_read_ctrl: RTL and testbench
================================

MEM_READ_CTRL -- requirements
Module: mem_read_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, memory address width (1024-word space).
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter WAIT_STATES, default 2, range 0..15, memory access wait cycles.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  read request from the CPU; sampled only in IDLE.
REQ-007 addr  input  ADDR_W  read address; captured with req.
REQ-008 abort  input  1  cancels an in-flight read before data is captured.
REQ-009 rack  input  1  CPU acknowledge of returned data.
REQ-010 mem_rdata  input  DATA_W  data from the memory array's read mux.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 mem_addr  output  ADDR_W  registered address driven to the memory read select.
REQ-013 mem_oe  output  1  memory output enable.
REQ-014 rdata  output  DATA_W  captured read data.
REQ-015 rvalid  output  1  rdata valid; high only in HOLD.
REQ-016 bus_en  output  1  tristate enable for driving rdata onto the shared data bus; equals rvalid.

Function
REQ-017 The FSM SHALL have states IDLE, SETUP, WAIT, CAPT and HOLD, all outputs registered or decoded from state only.
REQ-018 IDLE: req=1 at an edge SHALL latch addr into mem_addr and enter SETUP; req=0 stays IDLE.
REQ-019 SETUP: mem_oe=1; one cycle; SHALL load a 4-bit wait counter with WAIT_STATES; next WAIT if WAIT_STATES>0, else CAPT.
REQ-020 WAIT: mem_oe=1; SHALL last exactly WAIT_STATES cycles (counter decrements, exit to CAPT when it reaches 1).
REQ-021 CAPT: mem_oe=1; one cycle; rdata SHALL load mem_rdata on the edge leaving CAPT; next HOLD.
REQ-022 HOLD: mem_oe=0, rvalid=1, bus_en=1; SHALL stay until rack=1 is sampled, then IDLE.
REQ-023 Latency: rvalid SHALL rise exactly 3+WAIT_STATES cycles after the edge that sampled req.
REQ-024 req SHALL be ignored while busy=1, including req and rack high together in HOLD; the next request is accepted from IDLE one cycle later.
REQ-025 abort=1 in SETUP, WAIT or CAPT SHALL return to IDLE on the next edge without updating rdata or asserting rvalid; abort SHALL be ignored in IDLE and HOLD.
REQ-026 abort takes priority over the normal CAPT->HOLD transition in the same cycle.
REQ-027 rdata and mem_addr SHALL hold their last values in IDLE; rack in any state other than HOLD SHALL have no effect.
REQ-028 mem_rdata SHALL be sampled only at the CAPT edge; changes in other cycles SHALL NOT affect rdata.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock edge, force IDLE, busy=0, mem_oe=0, rvalid=0, bus_en=0, mem_addr=0, rdata=0 and wait counter=0.
REQ-030 Reset asserted mid-read (any state) SHALL discard the read; after release the block SHALL accept a new req on the first edge.

Verification
REQ-031 Basic read, WAIT_STATES=2: req with addr=0x155, mem_rdata=0xA5 -> mem_addr=0x155, mem_oe high for 4 cycles, rvalid and bus_en high 5 cycles after req, rdata=0xA5.
REQ-032 Zero wait, WAIT_STATES=0: req addr=0x3FF, mem_rdata=0x3C -> rvalid after 3 cycles, rdata=0x3C, no WAIT state visited.
REQ-033 Hold/ack: rack withheld 10 cycles -> rvalid stays 1, rdata stable; rack=1 with req=1 -> IDLE, req ignored; req next cycle accepted.
REQ-034 Abort: abort=1 in the 2nd WAIT cycle -> IDLE next edge, rvalid never asserted, rdata keeps previous value 0xA5.
REQ-035 Reset mid-operation: rst_n low during WAIT -> all outputs 0 asynchronously; after release req addr=0x001 completes normally.
REQ-036 Data stability: mem_rdata toggled every cycle except CAPT (0x5A there) -> rdata=0x5A.

Source files
------------

// File: rtl/mem_read_ctrl.sv
// Memory read controller: fixed SETUP/WAIT/CAPT sequence toward a memory array,
// with the captured word held on a valid/ack handshake until the CPU acknowledges it.
module mem_read_ctrl #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr,
   input  logic              abort,
   input  logic              rack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_oe,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   output logic              bus_en,
   output logic [2:0]        dbg_state
);

   // Handshake: rvalid/rdata stay stable from entry to HOLD until rack is
   // sampled high; req is only looked at in IDLE and is otherwise dropped.
   typedef enum logic [2:0] {
      st_idle  = 3'd0,
      st_setup = 3'd1,
      st_wait  = 3'd2,
      st_capt  = 3'd3,
      st_hold  = 3'd4
   } state_t;

   localparam logic [3:0] ws_load = 4'(WAIT_STATES);

   state_t     state, state_nxt;
   logic [3:0] wait_cnt, wait_cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= st_idle;
         wait_cnt <= 4'd0;
         mem_addr <= '0;
         rdata    <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (state == st_idle && req)
            mem_addr <= addr;
         // abort in CAPT wins, so the capture is suppressed with it
         if (state == st_capt && !abort)
            rdata <= mem_rdata;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         st_idle: begin
            if (req)
               state_nxt = st_setup;
         end
         st_setup: begin
            wait_cnt_nxt = ws_load;
            if (abort)
               state_nxt = st_idle;
            else if (WAIT_STATES > 0)
               state_nxt = st_wait;
            else
               state_nxt = st_capt;
         end
         st_wait: begin
            if (abort)
               state_nxt = st_idle;
            else if (wait_cnt <= 4'd1)
               state_nxt = st_capt;
            else
               wait_cnt_nxt = wait_cnt - 4'd1;
         end
         st_capt: begin
            if (abort)
               state_nxt = st_idle;
            else
               state_nxt = st_hold;
         end
         st_hold: begin
            if (rack)
               state_nxt = st_idle;
         end
         default: state_nxt = st_idle;
      endcase
   end

   assign busy      = (state != st_idle);
   assign mem_oe    = (state == st_setup) || (state == st_wait) || (state == st_capt);
   assign rvalid    = (state == st_hold);
   assign bus_en    = rvalid;
   assign dbg_state = state;

endmodule

// File: tb/tb_mem_read_ctrl.sv
// Bench for mem_read_ctrl: one instance with WAIT_STATES=2, one with WAIT_STATES=0,
// checked every cycle against a cycle-count model plus fixed vector tables.
module tb_mem_read_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       req_s[2], abort_s[2], rack_s[2];
   logic [9:0] addr_s[2];
   logic [7:0] mrd_s[2];
   logic       busy_o[2], oe_o[2], rv_o[2], be_o[2];
   logic [9:0] maddr_o[2];
   logic [7:0] rd_o[2];
   logic [2:0] st_o[2];

   mem_read_ctrl #(.ADDR_W(10), .DATA_W(8), .WAIT_STATES(2)) u_dut_ws2 (
      .clk(clk), .rst_n(rst_n), .req(req_s[0]), .addr(addr_s[0]), .abort(abort_s[0]),
      .rack(rack_s[0]), .mem_rdata(mrd_s[0]), .busy(busy_o[0]), .mem_addr(maddr_o[0]),
      .mem_oe(oe_o[0]), .rdata(rd_o[0]), .rvalid(rv_o[0]), .bus_en(be_o[0]),
      .dbg_state(st_o[0]));

   mem_read_ctrl #(.ADDR_W(10), .DATA_W(8), .WAIT_STATES(0)) u_dut_ws0 (
      .clk(clk), .rst_n(rst_n), .req(req_s[1]), .addr(addr_s[1]), .abort(abort_s[1]),
      .rack(rack_s[1]), .mem_rdata(mrd_s[1]), .busy(busy_o[1]), .mem_addr(maddr_o[1]),
      .mem_oe(oe_o[1]), .rdata(rd_o[1]), .rvalid(rv_o[1]), .bus_en(be_o[1]),
      .dbg_state(st_o[1]));

   int n_vec = 0;
   int n_err = 0;

   // Transaction model: age counts edges since the request was taken (-1 = none
   // in flight); the access completes when age reaches 1 + wait states.
   typedef struct {
      int         age;
      bit         hold;
      logic [9:0] maddr;
      logic [7:0] rd;
   } model_t;

   model_t mdl[2];

   function automatic model_t model_reset();
      model_t m;
      m.age = -1; m.hold = 1'b0; m.maddr = '0; m.rd = '0;
      return m;
   endfunction

   function automatic model_t model_step(model_t m, logic req, logic [9:0] addr,
                                         logic abort, logic rack, logic [7:0] mrd, int ws);
      model_t n = m;
      if (m.hold) begin
         if (rack) n.hold = 1'b0;
      end else if (m.age < 0) begin
         if (req) begin n.age = 0; n.maddr = addr; end
      end else if (abort) begin
         n.age = -1;
      end else if (m.age == 1 + ws) begin
         n.age = -1; n.hold = 1'b1; n.rd = mrd;
      end else begin
         n.age = m.age + 1;
      end
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("busy%0d", i),   32'(busy_o[i]),  32'((mdl[i].age >= 0) || mdl[i].hold));
         chk($sformatf("mem_oe%0d", i), 32'(oe_o[i]),    32'(mdl[i].age >= 0));
         chk($sformatf("rvalid%0d", i), 32'(rv_o[i]),    32'(mdl[i].hold));
         chk($sformatf("bus_en%0d", i), 32'(be_o[i]),    32'(mdl[i].hold));
         chk($sformatf("maddr%0d", i),  32'(maddr_o[i]), 32'(mdl[i].maddr));
         chk($sformatf("rdata%0d", i),  32'(rd_o[i]),    32'(mdl[i].rd));
      end
   endtask

   // One clock: model follows the inputs the DUT samples, outputs checked 1ns later.
   task automatic step();
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (!rst_n)
            mdl[i] = model_reset();
         else
            mdl[i] = model_step(mdl[i], req_s[i], addr_s[i], abort_s[i], rack_s[i],
                                mrd_s[i], (i == 0) ? 2 : 0);
      end
      #1;
      check_all();
   endtask

   typedef struct {
      logic       req;
      logic [9:0] addr;
      logic       abort;
      logic       rack;
      logic [7:0] mrd;
      logic       busy;
      logic       oe;
      logic       rvalid;
      logic [7:0] rdata;
      logic [9:0] maddr;
   } vec_t;

   vec_t tbl[7];

   initial begin
      // basic WAIT_STATES=2 read; expected values are after the edge sampling the row
      tbl[0] = '{1'b1, 10'h155, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 10'h155};
      tbl[1] = '{1'b0, 10'h000, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 10'h155};
      tbl[2] = '{1'b0, 10'h000, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 10'h155};
      tbl[3] = '{1'b0, 10'h000, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 10'h155};
      tbl[4] = '{1'b0, 10'h000, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 10'h155};
      tbl[5] = '{1'b0, 10'h000, 1'b0, 1'b0, 8'h44, 1'b1, 1'b0, 1'b1, 8'hA5, 10'h155};
      tbl[6] = '{1'b0, 10'h000, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'hA5, 10'h155};

      for (int i = 0; i < 2; i++) begin
         req_s[i] = 0; abort_s[i] = 0; rack_s[i] = 0; addr_s[i] = '0; mrd_s[i] = '0;
         mdl[i] = model_reset();
      end
      rst_n = 1'b0;
      #1;
      check_all();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // table-driven basic read
      for (int r = 0; r < 7; r++) begin
         req_s[0] = tbl[r].req; addr_s[0] = tbl[r].addr; abort_s[0] = tbl[r].abort;
         rack_s[0] = tbl[r].rack; mrd_s[0] = tbl[r].mrd;
         step();
         chk($sformatf("tbl%0d_busy", r),   32'(busy_o[0]),  32'(tbl[r].busy));
         chk($sformatf("tbl%0d_oe", r),     32'(oe_o[0]),    32'(tbl[r].oe));
         chk($sformatf("tbl%0d_rvalid", r), 32'(rv_o[0]),    32'(tbl[r].rvalid));
         chk($sformatf("tbl%0d_bus_en", r), 32'(be_o[0]),    32'(tbl[r].rvalid));
         chk($sformatf("tbl%0d_rdata", r),  32'(rd_o[0]),    32'(tbl[r].rdata));
         chk($sformatf("tbl%0d_maddr", r),  32'(maddr_o[0]), 32'(tbl[r].maddr));
      end
      rack_s[0] = 0;

      // abort during the second WAIT cycle
      req_s[0] = 1; addr_s[0] = 10'h2AA; mrd_s[0] = 8'h99;
      step();
      req_s[0] = 0;
      step();
      step();
      abort_s[0] = 1;
      step();
      abort_s[0] = 0;
      chk("abort_busy", 32'(busy_o[0]), 32'd0);
      chk("abort_rdata", 32'(rd_o[0]), 32'hA5);
      repeat (3) begin
         step();
         chk("abort_rvalid", 32'(rv_o[0]), 32'd0);
      end

      // HOLD with rack withheld, then rack+req together, then req accepted
      req_s[0] = 1; addr_s[0] = 10'h0F0; mrd_s[0] = 8'hC3;
      step();
      req_s[0] = 0;
      repeat (4) step();
      repeat (10) begin
         mrd_s[0] = 8'($urandom);
         step();
         chk("hold_rvalid", 32'(rv_o[0]), 32'd1);
         chk("hold_rdata", 32'(rd_o[0]), 32'hC3);
      end
      rack_s[0] = 1; req_s[0] = 1; addr_s[0] = 10'h111;
      step();
      chk("ack_busy", 32'(busy_o[0]), 32'd0);
      chk("ack_req_ignored", 32'(maddr_o[0]), 32'h0F0);
      rack_s[0] = 0;
      step();
      chk("next_req_busy", 32'(busy_o[0]), 32'd1);
      chk("next_req_maddr", 32'(maddr_o[0]), 32'h111);
      req_s[0] = 0;
      repeat (4) step();
      rack_s[0] = 1;
      step();
      rack_s[0] = 0;

      // mem_rdata toggling, 0x5A only in the CAPT cycle
      req_s[0] = 1; addr_s[0] = 10'h033; mrd_s[0] = 8'h00;
      step();
      req_s[0] = 0;
      for (int k = 1; k <= 4; k++) begin
         mrd_s[0] = (k == 4) ? 8'h5A : 8'($urandom_range(0, 8'h59));
         step();
      end
      chk("stab_rdata", 32'(rd_o[0]), 32'h5A);
      mrd_s[0] = 8'hFF;
      rack_s[0] = 1;
      step();
      rack_s[0] = 0;

      // asynchronous reset during WAIT, then a fresh read
      req_s[0] = 1; addr_s[0] = 10'h155;
      step();
      req_s[0] = 0;
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", 32'(busy_o[0]), 32'd0);
      chk("rst_oe", 32'(oe_o[0]), 32'd0);
      chk("rst_rvalid", 32'(rv_o[0]), 32'd0);
      chk("rst_bus_en", 32'(be_o[0]), 32'd0);
      chk("rst_maddr", 32'(maddr_o[0]), 32'd0);
      chk("rst_rdata", 32'(rd_o[0]), 32'd0);
      for (int i = 0; i < 2; i++) mdl[i] = model_reset();
      step();
      rst_n = 1'b1;
      req_s[0] = 1; addr_s[0] = 10'h001; mrd_s[0] = 8'h6E;
      step();
      chk("post_rst_maddr", 32'(maddr_o[0]), 32'h001);
      req_s[0] = 0;
      repeat (4) step();
      chk("post_rst_rvalid", 32'(rv_o[0]), 32'd1);
      chk("post_rst_rdata", 32'(rd_o[0]), 32'h6E);
      rack_s[0] = 1;
      step();
      rack_s[0] = 0;

      // zero wait states: the sampling edge starts cycle 1, rvalid appears in cycle 3
      req_s[1] = 1; addr_s[1] = 10'h3FF; mrd_s[1] = 8'h3C;
      step();
      req_s[1] = 0;
      chk("ws0_no_wait_a", 32'(st_o[1] == 3'd2), 32'd0);
      step();
      chk("ws0_no_wait_b", 32'(st_o[1] == 3'd2), 32'd0);
      chk("ws0_rvalid_early", 32'(rv_o[1]), 32'd0);
      step();
      chk("ws0_rvalid", 32'(rv_o[1]), 32'd1);
      chk("ws0_rdata", 32'(rd_o[1]), 32'h3C);
      chk("ws0_maddr", 32'(maddr_o[1]), 32'h3FF);
      rack_s[1] = 1;
      step();
      rack_s[1] = 0;

      // random traffic on both instances against the model
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 2; i++) begin
            req_s[i]   = ($urandom_range(0, 2) == 0);
            abort_s[i] = ($urandom_range(0, 11) == 0);
            rack_s[i]  = ($urandom_range(0, 3) == 0);
            addr_s[i]  = 10'($urandom);
            mrd_s[i]   = 8'($urandom);
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
